// File: rtl/xrst_settlement_scheduler.sv
// xrst_settlement_scheduler: round-robin arbiter that issues one settlement record at a time
// to the XRST settlement layer, waits GAP cycles, then reports a tagged completion.
module xrst_settlement_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int GAP = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*232-1:0] req_payload,
    output logic                   settlement_valid,
    output logic [31:0]            sla_id,
    output logic [31:0]            timestamp,
    output logic [31:0]            reliability_score,
    output logic [31:0]            settlement_a,
    output logic [31:0]            settlement_b,
    output logic [31:0]            settlement_c,
    output logic [31:0]            remaining_stake,
    output logic [7:0]             sla_status,
    input  logic [31:0]            risk_index,
    input  logic [7:0]             compliance_level,
    output logic                   done_valid,
    output logic [2:0]             done_id,
    output logic [31:0]            done_seq,
    output logic [31:0]            done_risk,
    output logic [7:0]             done_compliance,
    output logic                   busy,
    output logic [31:0]            settle_count
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    state_t state, state_nxt;
    logic [2:0] last_grant, cur_id, win;
    logic [31:0] cur_seq;
    logic [3:0] wait_cnt;
    logic done_pending, found, grant;
    logic [231:0] sel;

    // search starts just past the previous winner so every requester gets a turn
    always_comb begin
        win = last_grant;
        sel = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!found && req_valid[(int'(last_grant) + k) % NUM_REQ]) begin
                win = 3'((int'(last_grant) + k) % NUM_REQ);
                sel = req_payload[((int'(last_grant) + k) % NUM_REQ) * 232 +: 232];
                found = 1'b1;
            end
        end
    end

    assign grant = (state == IDLE) && enable && found;
    assign req_ready = grant ? NUM_REQ'(1) << win : '0;

    always_comb begin
        state_nxt = state == IDLE  ? (grant ? ISSUE : IDLE) :
                    state == ISSUE ? WAIT :
                    (wait_cnt == 4'd0 ? IDLE : WAIT);
    end

    assign settlement_valid = (state == ISSUE);
    assign busy = (state != IDLE);
    assign done_valid = done_pending;
    assign done_id = done_pending ? cur_id : 3'd0;
    assign done_seq = done_pending ? cur_seq : 32'd0;
    assign done_risk = done_pending ? risk_index : 32'd0;
    assign done_compliance = done_pending ? compliance_level : 8'd0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            last_grant <= 3'(NUM_REQ - 1);
            cur_id <= 3'd0;
            cur_seq <= 32'd0;
            wait_cnt <= 4'd0;
            done_pending <= 1'b0;
            settle_count <= 32'd0;
            {sla_status, remaining_stake, settlement_c, settlement_b, settlement_a,
             reliability_score, timestamp, sla_id} <= '0;
        end else begin
            state <= state_nxt;
            done_pending <= (state == WAIT) && (wait_cnt == 4'd0);
            if (grant) begin
                {sla_status, remaining_stake, settlement_c, settlement_b, settlement_a,
                 reliability_score, timestamp, sla_id} <= sel;
                last_grant <= win;
                cur_id <= win;
            end
            if (state == ISSUE) begin
                cur_seq <= settle_count;
                settle_count <= settle_count + 32'd1;
                wait_cnt <= 4'(GAP - 1);
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_xrst_settlement_scheduler.sv
// tb_xrst_settlement_scheduler: directed checks of arbitration order, issue/complete timing,
// enable gating, mid-flight reset and sequence-number wrap.
module tb_xrst_settlement_scheduler;
    localparam int N = 4;
    localparam int G = 2;

    logic clk = 1'b0;
    logic rst_n, enable;
    logic [N-1:0] req_valid, req_ready;
    logic [N*232-1:0] req_payload;
    logic settlement_valid;
    logic [31:0] sla_id, timestamp, reliability_score, settlement_a, settlement_b, settlement_c, remaining_stake;
    logic [7:0] sla_status;
    logic [31:0] risk_index;
    logic [7:0] compliance_level;
    logic done_valid;
    logic [2:0] done_id;
    logic [31:0] done_seq, done_risk;
    logic [7:0] done_compliance;
    logic busy;
    logic [31:0] settle_count;
    int checks = 0;
    int fails = 0;

    xrst_settlement_scheduler #(.NUM_REQ(N), .GAP(G)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .req_valid(req_valid), .req_ready(req_ready), .req_payload(req_payload),
        .settlement_valid(settlement_valid), .sla_id(sla_id), .timestamp(timestamp),
        .reliability_score(reliability_score), .settlement_a(settlement_a),
        .settlement_b(settlement_b), .settlement_c(settlement_c),
        .remaining_stake(remaining_stake), .sla_status(sla_status),
        .risk_index(risk_index), .compliance_level(compliance_level),
        .done_valid(done_valid), .done_id(done_id), .done_seq(done_seq),
        .done_risk(done_risk), .done_compliance(done_compliance),
        .busy(busy), .settle_count(settle_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [231:0] mk(input int i);
        return {8'(i + 1), 32'(500 + i), 32'(300 + i), 32'(200 + i), 32'(100 + i),
                32'(950 + 5 * i), 32'(1000 + i), 32'(32'hA000 + i)};
    endfunction

    // Entered in an IDLE cycle where requester id must win; returns in its done cycle (T+2+G).
    task automatic settle(input int id, input logic [31:0] seq, input bit drop);
        #1;
        check("grant", 64'(req_ready), 64'(1) << id);
        tick();
        if (drop) req_valid[id] = 1'b0;
        #1;
        check("issue_pulse", 64'(settlement_valid), 64'd1);
        check("issue_ready", 64'(req_ready), 64'd0);
        check("sla_id", 64'(sla_id), 64'(32'hA000 + id));
        check("reliability", 64'(reliability_score), 64'(950 + 5 * id));
        check("status", 64'(sla_status), 64'(id + 1));
        for (int c = 0; c < G; c++) begin
            tick();
            check("wait_busy", 64'(busy), 64'd1);
            check("wait_ready", 64'(req_ready), 64'd0);
            check("wait_done", 64'(done_valid), 64'd0);
        end
        tick();
        check("done_valid", 64'(done_valid), 64'd1);
        check("done_id", 64'(done_id), 64'(id));
        check("done_seq", 64'(done_seq), 64'(seq));
        check("done_risk", 64'(done_risk), 64'(risk_index));
        check("done_comp", 64'(done_compliance), 64'(compliance_level));
    endtask

    initial begin
        rst_n = 1'b0;
        enable = 1'b0;
        req_valid = '0;
        risk_index = 32'd10;
        compliance_level = 8'd100;
        for (int i = 0; i < N; i++) req_payload[i*232 +: 232] = mk(i);
        tick();
        tick();
        check("rst_ready", 64'(req_ready), 64'd0);
        check("rst_issue", 64'(settlement_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_count", 64'(settle_count), 64'd0);
        check("rst_done", 64'(done_valid), 64'd0);
        check("rst_sla", 64'(sla_id), 64'd0);

        // single requester 2 (reliability 960)
        rst_n = 1'b1;
        enable = 1'b1;
        req_valid = 4'b0100;
        settle(2, 32'd0, 1'b1);
        check("single_count", 64'(settle_count), 64'd1);
        tick();
        check("single_done_low", 64'(done_valid), 64'd0);

        // all four valid: 0,1,2,3,0 back to back
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req_valid = 4'hF;
        for (int g = 0; g < 5; g++) settle(g % 4, 32'(g), 1'b0);
        req_valid = '0;
        tick();
        check("rr_idle", 64'(busy), 64'd0);

        // last_grant=1 with 0 and 3 pending: 3 before 0
        req_valid = 4'b0010;
        settle(1, 32'd5, 1'b1);
        req_valid = 4'b1001;
        settle(3, 32'd6, 1'b1);
        settle(0, 32'd7, 1'b1);

        // enable dropped while in flight
        req_valid = 4'b0100;
        #1;
        check("en_grant", 64'(req_ready), 64'b0100);
        tick();
        enable = 1'b0;
        req_valid = 4'b0001;
        tick();
        tick();
        tick();
        check("en_done", 64'(done_valid), 64'd1);
        check("en_seq", 64'(done_seq), 64'd8);
        check("en_ready_off", 64'(req_ready), 64'd0);
        tick();
        check("en_ready_off2", 64'(req_ready), 64'd0);
        check("en_idle", 64'(busy), 64'd0);
        enable = 1'b1;
        settle(0, 32'd9, 1'b1);

        // reset while in WAIT
        req_valid = 4'b0010;
        tick();
        req_valid = '0;
        tick();
        rst_n = 1'b0;
        tick();
        check("mid_busy", 64'(busy), 64'd0);
        check("mid_count", 64'(settle_count), 64'd0);
        check("mid_done", 64'(done_valid), 64'd0);
        check("mid_sla", 64'(sla_id), 64'd0);
        check("mid_ready", 64'(req_ready), 64'd0);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("mid_no_done", 64'(done_valid), 64'd0);
        end
        req_valid = 4'hF;
        settle(0, 32'd0, 1'b1);
        req_valid = '0;
        tick();

        // sequence wrap
        risk_index = 32'd77;
        compliance_level = 8'd55;
        force dut.settle_count = 32'hFFFF_FFFF;
        #1;
        release dut.settle_count;
        req_valid = 4'b0010;
        settle(1, 32'hFFFF_FFFF, 1'b1);
        check("wrap_count", 64'(settle_count), 64'd0);
        req_valid = 4'b0100;
        settle(2, 32'd0, 1'b1);
        check("wrap_count2", 64'(settle_count), 64'd1);
        req_valid = '0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/xrst_settlement_scheduler.md
# xrst_settlement_scheduler

Round-robin scheduler that shares the single XRST regulated settlement layer between `NUM_REQ` SLA requesters. It accepts one settlement record at a time over a valid/ready handshake and registers it. It drives a one-cycle `settlement_valid` pulse with the record onto the settlement layer, then holds off for `GAP` cycles so the audit pipeline settles. It then returns a completion tagged with requester id, sequence number and the resulting risk/compliance values.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `GAP`, default 2: wait cycles after issue, 1..15.
- `clk` in 1: clock; all logic on rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `enable` in 1: when low, no new grant; an in-flight settlement completes.
- `req_valid` in NUM_REQ: per-requester record valid.
- `req_ready` out NUM_REQ: one-hot grant; the transfer occurs when `req_valid[i] & req_ready[i]`.
- `req_payload` in NUM_REQ*232: per requester i, slice [i*232 +: 232], packed as follows:
  - [31:0] sla_id
  - [63:32] timestamp
  - [95:64] reliability_score
  - [127:96] settlement_a
  - [159:128] settlement_b
  - [191:160] settlement_c
  - [223:192] remaining_stake
  - [231:224] sla_status
- `settlement_valid` out 1: one-cycle issue pulse to the settlement layer.
- `sla_id`, `timestamp`, `reliability_score`, `settlement_a`, `settlement_b`, `settlement_c`, `remaining_stake` out 32 each: registered record to the settlement layer.
- `sla_status` out 8: registered record to the settlement layer.
- `risk_index` in 32: from the settlement layer.
- `compliance_level` in 8: from the settlement layer.
- `done_valid` out 1: one-cycle completion pulse.
- `done_id` out 3: index of the requester that completed.
- `done_seq` out 32: sequence number of the completed settlement.
- `done_risk` out 32: `risk_index` sampled at completion.
- `done_compliance` out 8: `compliance_level` sampled at completion.
- `busy` out 1: high in ISSUE and WAIT.
- `settle_count` out 32: number of settlements issued since reset; wraps.

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- **IDLE**
  - If `enable` and any `req_valid` is high, the winner is the first requester with valid set, searching from `last_grant+1` modulo NUM_REQ.
  - `req_ready` is asserted combinationally, one-hot, for the winner only, in this cycle only.
  - On the clock edge: payload fields are captured into the output registers, `last_grant` becomes the winner, `cur_id` becomes the winner, and the FSM goes to ISSUE.
  - `req_ready` is all zero in ISSUE, in WAIT, and while `enable` is low.
- **ISSUE**
  - `settlement_valid` = 1 for exactly this cycle.
  - `cur_seq` is set to `settle_count`, then `settle_count` increments, wrapping from 0xFFFFFFFF to 0.
  - FSM goes to WAIT and the wait counter loads `GAP-1`.
- **WAIT**
  - The counter decrements each cycle. When it reaches 0, the FSM goes to IDLE and `done_pending` is set.
- **Completion**
  - In the first IDLE cycle after WAIT: `done_valid` = 1; `done_id` = `cur_id`; `done_seq` = `cur_seq`; `done_risk` and `done_compliance` are sampled from the inputs.
  - Arbitration in that same cycle is permitted.
- Record output registers hold their value until the next grant.
- Requesters must hold `req_valid` and payload stable until granted. Deasserting `req_valid` before grant withdraws the request, with no side effect.
- Reset values:
  - `last_grant` = NUM_REQ-1, so requester 0 has first priority.
  - All outputs are 0: `req_ready`, `settlement_valid`, all record fields, `done_*`, `busy`, `settle_count`.
  - FSM = IDLE.
- Reset mid-operation: everything returns to reset values on the next edge. No `done_valid` is produced for the aborted settlement.

## Timing
- Grant/accept at cycle T (IDLE).
- `settlement_valid` and record outputs valid at T+1.
- WAIT occupies T+2 .. T+1+GAP.
- `done_valid` at T+2+GAP, where the next grant may also occur.
- Sustained throughput: one settlement per GAP+2 cycles; 4 cycles at GAP=2.
- The settlement layer updates `risk_index`/`compliance_level` at T+2, so the sample at T+2+GAP is always valid for GAP≥1.
- `enable` is sampled in IDLE only. Dropping it during ISSUE/WAIT does not abort; `done_valid` still fires.

## Test plan
- **Single requester:** req 2 valid, reliability 960, GAP=2. Required response:
  - `req_ready`=4'b0100 at T.
  - `settlement_valid` at T+1 with matching fields.
  - `done_valid` at T+4 with id 2, seq 0, risk 10, compliance 100.
- **All four valid continuously:** grants in order 0,1,2,3,0, spaced 4 cycles apart; `done_seq` 0..4; never two `req_ready` bits high.
- **Fairness after last_grant=1 with req 0 and 3 valid:** req 3 is granted before req 0.
- **enable low at T+1 of an in-flight settlement:** `done_valid` still fires at T+4; no further `req_ready` while `enable` is low; granting resumes the cycle after `enable` returns high.
- **rst_n low during WAIT:** next cycle all outputs are 0 and no `done_valid` appears; after release the first grant goes to req 0 and seq restarts at 0.
- **`settle_count` forced near wrap (0xFFFFFFFF):** `done_seq`=0xFFFFFFFF, then 0 on the following settlement.
